// File: rtl/spm_ctrl_pkg.sv
// spm_ctrl_pkg: shared types and helpers for the spm sequencer.
//   spm_ctrl_state_t : controller state (IDLE, RUN, DONE)
//   cnt_width()      : bits needed to count 0 .. 2*size inclusive
package spm_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } spm_ctrl_state_t;

  // clog2(2*size+1), written out so it stays a plain constant function
  function automatic int cnt_width(input int size);
    int v;
    int w;
    v = 2 * size + 1;
    w = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) w = i + 1;
    return w;
  endfunction

endpackage

// File: rtl/spm.sv
// spm: signed serial-parallel multiplier.
//   Parameter size : width of parallel operand x.
//   clk, rst       : posedge clock, async active-high reset
//   ld             : synchronous clear of all internal state (hold while idle)
//   x   [size-1:0] : parallel multiplicand, two's complement, held stable
//   y              : serial multiplier bit, LSB first, sign-extended stream
//   p              : serial product bit, registered; bit k of the product
//                    appears the cycle after y bit k was presented
// Each cycle the running partial sum absorbs x (if y=1), emits its LSB as a
// product bit and shifts right arithmetically. Because the y stream is
// sign-extended, 2*size cycles produce the full two's-complement product.
module spm #(
  parameter int size = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ld,
  input  logic [size-1:0] x,
  input  logic            y,
  output logic            p
);

  // Two guard bits: |acc| never exceeds |x|, and acc + x needs one more.
  localparam int AW = size + 2;

  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] sum;
  logic signed [AW-1:0] x_ext;

  assign x_ext = AW'($signed(x));

  always_comb begin
    sum = acc;
    if (y) sum = acc + x_ext;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      p   <= 1'b0;
    end else if (ld) begin
      acc <= '0;
      p   <= 1'b0;
    end else begin
      p   <= sum[0];
      acc <= sum >>> 1;
    end
  end

endmodule

// File: rtl/spm_ctrl.sv
// spm_ctrl: sequencer around the serial-parallel multiplier spm.
//   Parameter SIZE : operand width (>= 2)
//   clk, rst       : posedge clock, async active-high reset (shared with spm)
//   in_valid/in_ready, in_x, in_y : operand handshake (in_ready high in IDLE)
//   out_valid/out_ready, out_p    : 2*SIZE-bit signed product handshake
//   busy           : high in RUN or DONE
//   abort          : cancel request, only when SPM_CTRL_ABORT_EN is defined
// Optional feature macro: SPM_CTRL_ABORT_EN (adds abort port and behaviour).
// After accept, RUN feeds y LSB first for 2*SIZE+1 cycles (cnt 0..2*SIZE);
// spm's registered output lags one cycle, so product bits are captured from
// cnt=1 onward, shifting in at the MSB end of p_q.
module spm_ctrl
  import spm_ctrl_pkg::*;
#(
  parameter int SIZE = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SIZE-1:0]   in_x,
  input  logic [SIZE-1:0]   in_y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*SIZE-1:0] out_p,
`ifdef SPM_CTRL_ABORT_EN
  input  logic              abort,
`endif
  output logic              busy
);

  localparam int CW = cnt_width(SIZE);
  localparam logic [CW-1:0] LAST = CW'(2 * SIZE);

  spm_ctrl_state_t   state;
  logic [CW-1:0]     cnt;
  logic [SIZE-1:0]   x_q;
  logic [SIZE-1:0]   y_q;
  logic [2*SIZE-1:0] p_q;
  logic              ld_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              busy_q;
  logic              spm_p;
  logic              abort_req;

`ifdef SPM_CTRL_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_p     = p_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      x_q         <= '0;
      y_q         <= '0;
      p_q         <= '0;
      ld_q        <= 1'b1;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // abort is meaningless here; a pending operand is taken normally
          if (in_valid && in_ready_q) begin
            state      <= RUN;
            x_q        <= in_x;
            y_q        <= in_y;
            cnt        <= '0;
            p_q        <= '0;
            ld_q       <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          if (abort_req) begin
            state      <= IDLE;
            ld_q       <= 1'b1;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end else begin
            // arithmetic shift keeps feeding the sign bit past bit SIZE-1
            y_q <= {y_q[SIZE-1], y_q[SIZE-1:1]};
            if (cnt != '0) p_q <= {spm_p, p_q[2*SIZE-1:1]};
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
              state       <= DONE;
              ld_q        <= 1'b1;
              out_valid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          // abort wins over a simultaneous handshake: product not delivered
          if (abort_req || out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          ld_q        <= 1'b1;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  spm #(
    .size(SIZE)
  ) u_spm (
    .clk (clk),
    .rst (rst),
    .ld  (ld_q),
    .x   (x_q),
    .y   (y_q[0]),
    .p   (spm_p)
  );

endmodule
